tmds_link_scheduler: RTL and testbench

- Sequences the per-channel 10-bit symbol stream fed to the TMDS serializer for 640x480@60.
- Runs the pixel timing counters and requests pixels from the TMDS encoder path.
- Inserts control tokens during blanking and, in HDMI mode, the video preamble and guard band.
- Emits TMDS_red/green/blue aligned to pixclk, plus frame/line markers for the game logic.

---
 rtl/tmds_pkg.sv | 42 ++++
 rtl/video_timing_counter.sv | 97 +++++++++
 rtl/tmds_link_scheduler.sv | 134 +++++++++++++
 tb/tb_tmds_link_scheduler.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS symbol constants, lane region codes and default 640x480@60 timing.
package tmds_pkg;

  typedef enum logic [1:0] {
    CTRL,
    PREAMBLE,
    GUARD,
    ACTIVE
  } region_t;

  // Per-cycle lane control travelling down the alignment pipeline.
  typedef struct packed {
    region_t region;
    logic    hsync;
    logic    vsync;
  } lane_ctl_t;

  localparam logic [9:0] CTRL_TOKEN [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  localparam logic [9:0] VGB_BLUE  = 10'b1011001100;
  localparam logic [9:0] VGB_GREEN = 10'b0100110011;
  localparam logic [9:0] VGB_RED   = 10'b1011001100;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
    return CTRL_TOKEN[{c1, c0}];
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Pixel timing counters, pixel request timeline, sync levels and per-cycle
// lane region classification on the request timeline.
module video_timing_counter
  import tmds_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit SYNC_POL  = 1'b0,
  parameter bit HDMI_MODE = 1'b1,
  parameter int PRE_LEN   = 8,
  parameter int GB_LEN    = 2
) (
  input  logic       pixclk,
  input  logic       rst_n,
  output logic       pix_req,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_start,
  output logic       line_start,
  output region_t    region,
  output logic       hsync,
  output logic       vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA        = 10'(H_ACTIVE);
  localparam logic [9:0] VA        = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] GB_START  = 10'(H_TOTAL - GB_LEN);
  localparam logic [9:0] PRE_START = 10'(H_TOTAL - GB_LEN - PRE_LEN);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] v_next;
  logic       run;
  logic       active;
  logic       next_active;

  // run holds the counters at 0,0 for the first cycle after release so that
  // cycle is the first pixel of a frame rather than a reset artefact.
  always_ff @(posedge pixclk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= v_next;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  always_comb begin
    v_next      = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    next_active = (v_next < VA);
    active      = run && (h_cnt < HA) && (v_cnt < VA);

    pix_req     = active;
    pix_x       = active ? h_cnt : '0;
    pix_y       = active ? v_cnt : '0;
    frame_start = run && (h_cnt == '0) && (v_cnt == '0);
    line_start  = run && (h_cnt == '0);

    hsync = ~SYNC_POL;
    vsync = ~SYNC_POL;
    if (run && (h_cnt >= HS_START) && (h_cnt < HS_END)) hsync = SYNC_POL;
    if (run && (v_cnt >= VS_START) && (v_cnt < VS_END)) vsync = SYNC_POL;

    region = CTRL;
    if (active) begin
      region = ACTIVE;
    end else if (run && HDMI_MODE && next_active) begin
      if (h_cnt >= GB_START)       region = GUARD;
      else if (h_cnt >= PRE_START) region = PREAMBLE;
    end
  end

endmodule

// File: rtl/tmds_link_scheduler.sv
// TMDS link scheduler: aligns region/sync with the encoder latency and muxes
// pixel symbols, control tokens, preamble and guard band onto the three lanes.
module tmds_link_scheduler
  import tmds_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit SYNC_POL  = 1'b0,
  parameter bit HDMI_MODE = 1'b1,
  parameter int PRE_LEN   = 8,
  parameter int GB_LEN    = 2,
  parameter int ENC_LAT   = 1
) (
  input  logic       pixclk,
  input  logic       rst_n,
  output logic       pix_req,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  input  logic [9:0] enc_red,
  input  logic [9:0] enc_green,
  input  logic [9:0] enc_blue,
  output logic       enc_de,
  output logic [9:0] TMDS_red,
  output logic [9:0] TMDS_green,
  output logic [9:0] TMDS_blue,
  output logic       frame_start,
  output logic       line_start
);

  if (H_BP < PRE_LEN + GB_LEN) begin : g_bad_back_porch
    $error("tmds_link_scheduler: H_BP must be >= PRE_LEN + GB_LEN");
  end
  if ((ENC_LAT < 0) || (ENC_LAT > 4)) begin : g_bad_enc_lat
    $error("tmds_link_scheduler: ENC_LAT must be within 0..4");
  end

  localparam lane_ctl_t CTL_IDLE = '{region: CTRL, hsync: ~SYNC_POL, vsync: ~SYNC_POL};

  region_t   region;
  logic      hsync;
  logic      vsync;
  lane_ctl_t ctl_now;
  lane_ctl_t ctl_tail;
  logic [9:0] red_d;
  logic [9:0] green_d;
  logic [9:0] blue_d;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .HDMI_MODE(HDMI_MODE),
    .PRE_LEN  (PRE_LEN),
    .GB_LEN   (GB_LEN)
  ) u_timing (
    .pixclk     (pixclk),
    .rst_n      (rst_n),
    .pix_req    (pix_req),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_start(frame_start),
    .line_start (line_start),
    .region     (region),
    .hsync      (hsync),
    .vsync      (vsync)
  );

  assign ctl_now = '{region: region, hsync: hsync, vsync: vsync};

  // ENC_LAT stages so the region code meets the encoder output it describes.
  if (ENC_LAT == 0) begin : g_no_delay
    assign ctl_tail = ctl_now;
  end else begin : g_delay
    lane_ctl_t dly [ENC_LAT];

    always_ff @(posedge pixclk) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < ENC_LAT; i++) dly[i] <= CTL_IDLE;
      end else begin
        dly[0] <= ctl_now;
        for (int unsigned i = 1; i < ENC_LAT; i++) dly[i] <= dly[i-1];
      end
    end

    assign ctl_tail = dly[ENC_LAT-1];
  end

  assign enc_de = (ctl_tail.region == ACTIVE);

  always_comb begin
    red_d   = CTRL_TOKEN[0];
    green_d = CTRL_TOKEN[0];
    blue_d  = ctrl_token(ctl_tail.vsync, ctl_tail.hsync);
    case (ctl_tail.region)
      ACTIVE: begin
        red_d   = enc_red;
        green_d = enc_green;
        blue_d  = enc_blue;
      end
      PREAMBLE: green_d = CTRL_TOKEN[1];
      GUARD: begin
        red_d   = VGB_RED;
        green_d = VGB_GREEN;
        blue_d  = VGB_BLUE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pixclk) begin
    if (!rst_n) begin
      TMDS_red   <= CTRL_TOKEN[0];
      TMDS_green <= CTRL_TOKEN[0];
      TMDS_blue  <= ctrl_token(~SYNC_POL, ~SYNC_POL);
    end else begin
      TMDS_red   <= red_d;
      TMDS_green <= green_d;
      TMDS_blue  <= blue_d;
    end
  end

endmodule

// File: tb/tb_tmds_link_scheduler.sv
// Bench for tmds_link_scheduler: two instances (HDMI/ENC_LAT=1/neg sync and
// DVI/ENC_LAT=4/pos sync) on a reduced raster against a cycle-position model.
module tb_tmds_link_scheduler;

  localparam int HA = 16, HFP = 4, HS = 6, HBP = 12;
  localparam int VA = 6,  VFP = 2, VS = 2, VBP = 3;
  localparam int PRE = 8, GB = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int NCYC = 3000;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [29:0] GUARD_SYMS = {10'b1011001100, 10'b0100110011, 10'b1011001100};

  logic pixclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 pixclk = ~pixclk;

  logic [29:0] enc_a = '0;
  logic [29:0] enc_b = '0;
  logic        a_req, a_fs, a_ls, a_de;
  logic [9:0]  a_x, a_y, a_r, a_g, a_b;
  logic        b_req, b_fs, b_ls, b_de;
  logic [9:0]  b_x, b_y, b_r, b_g, b_b;

  tmds_link_scheduler #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .HDMI_MODE(1'b1), .PRE_LEN(PRE), .GB_LEN(GB), .ENC_LAT(1)
  ) dut_a (
    .pixclk(pixclk), .rst_n(rst_n),
    .pix_req(a_req), .pix_x(a_x), .pix_y(a_y),
    .enc_red(enc_a[29:20]), .enc_green(enc_a[19:10]), .enc_blue(enc_a[9:0]),
    .enc_de(a_de), .TMDS_red(a_r), .TMDS_green(a_g), .TMDS_blue(a_b),
    .frame_start(a_fs), .line_start(a_ls)
  );

  tmds_link_scheduler #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b1), .HDMI_MODE(1'b0), .PRE_LEN(PRE), .GB_LEN(GB), .ENC_LAT(4)
  ) dut_b (
    .pixclk(pixclk), .rst_n(rst_n),
    .pix_req(b_req), .pix_x(b_x), .pix_y(b_y),
    .enc_red(enc_b[29:20]), .enc_green(enc_b[19:10]), .enc_blue(enc_b[9:0]),
    .enc_de(b_de), .TMDS_red(b_r), .TMDS_green(b_g), .TMDS_blue(b_b),
    .frame_start(b_fs), .line_start(b_ls)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [29:0] pix_mem [2][HA*VA];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] tok(input logic vs, input logic hs);
    case ({vs, hs})
      2'b00:   return TOK00;
      2'b01:   return TOK01;
      2'b10:   return TOK10;
      default: return TOK11;
    endcase
  endfunction

  function automatic bit is_active(input int q);
    return ((q % HT) < HA) && ((q / HT) < VA);
  endfunction

  // Expected {red,green,blue} at cycle c: the symbol for raster position c-lat-1.
  function automatic logic [29:0] exp_tmds(input int id, input bit mode, input bit pol,
                                           input int lat, input int c);
    int p, q, h, v, nv;
    logic hs, vs;
    p = c - lat - 1;
    if (p < 0) return {TOK00, TOK00, tok(~pol, ~pol)};
    q = p % FT;
    h = q % HT;
    v = q / HT;
    if (is_active(q)) return pix_mem[id][v*HA + h];
    hs = (h >= HA + HFP && h < HA + HFP + HS) ? pol : ~pol;
    vs = (v >= VA + VFP && v < VA + VFP + VS) ? pol : ~pol;
    nv = (v + 1) % VT;
    if (mode && nv < VA && (HT - 1 - h) < GB) return GUARD_SYMS;
    if (mode && nv < VA && (HT - 1 - h) < GB + PRE) return {TOK00, TOK01, tok(vs, hs)};
    return {TOK00, TOK00, tok(vs, hs)};
  endfunction

  function automatic logic [29:0] enc_value(input int id, input int lat, input int c);
    int q;
    if (c >= lat) begin
      q = (c - lat) % FT;
      if (is_active(q)) return pix_mem[id][(q / HT)*HA + (q % HT)];
    end
    return 30'($urandom);
  endfunction

  task automatic check_dut(input string nm, input int id, input bit mode, input bit pol,
                           input int lat, input int c, input int k,
                           input logic req, input logic [9:0] x, input logic [9:0] y,
                           input logic fs, input logic ls, input logic de,
                           input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    int q;
    bit act, de_exp;
    q      = (c < 0) ? 0 : c % FT;
    act    = (c >= 0) && is_active(q);
    de_exp = (c >= lat) && is_active((c - lat) % FT);
    check_eq($sformatf("%s.pix_req@%0d", nm, k), 32'(req), 32'(act));
    check_eq($sformatf("%s.pix_x@%0d", nm, k), 32'(x), act ? 32'(q % HT) : 32'd0);
    check_eq($sformatf("%s.pix_y@%0d", nm, k), 32'(y), act ? 32'(q / HT) : 32'd0);
    check_eq($sformatf("%s.frame_start@%0d", nm, k), 32'(fs), 32'((c >= 0) && (q == 0)));
    check_eq($sformatf("%s.line_start@%0d", nm, k), 32'(ls), 32'((c >= 0) && (q % HT == 0)));
    check_eq($sformatf("%s.enc_de@%0d", nm, k), 32'(de), 32'(de_exp));
    check_eq($sformatf("%s.tmds@%0d", nm, k), 32'({r, g, b}),
             32'(exp_tmds(id, mode, pol, lat, (c < 0) ? -1000 : c)));
  endtask

  initial begin
    int c, r1, rl, de_cnt_b;
    c        = -1;
    de_cnt_b = 0;
    r1 = $urandom_range(1300, 1800);
    rl = $urandom_range(1, 3);
    for (int id = 0; id < 2; id++)
      for (int i = 0; i < HA*VA; i++) pix_mem[id][i] = 30'($urandom);

    for (int k = 0; k < NCYC; k++) begin
      rst_n = !((k < 3) || (k >= r1 && k < r1 + rl));
      @(posedge pixclk);
      #1;
      c = rst_n ? c + 1 : -1;

      check_dut("a", 0, 1'b1, 1'b0, 1, c, k, a_req, a_x, a_y, a_fs, a_ls, a_de, a_r, a_g, a_b);
      check_dut("b", 1, 1'b0, 1'b1, 4, c, k, b_req, b_x, b_y, b_fs, b_ls, b_de, b_r, b_g, b_b);

      if (k < r1 && c >= FT && c < 2*FT && b_de) de_cnt_b++;
      if (k < r1 && c == 2*FT) check_eq("b.enc_de_per_frame", 32'(de_cnt_b), 32'(HA*VA));

      enc_a = enc_value(0, 1, c);
      enc_b = enc_value(1, 4, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
